// File: rtl/trap_ctrl_pkg.sv
// Shared constants and types for the trap controller: CSR addresses, mcause codes,
// status bit positions, event kinds and FSM encoding.
package trap_ctrl_pkg;

    localparam int unsigned CPU_WIDTH = 32;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [CPU_WIDTH-1:0] CAUSE_ECALL   = 32'd11;
    localparam logic [CPU_WIDTH-1:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [CPU_WIDTH-1:0] CAUSE_EXT_IRQ = 32'h8000_000B;
    localparam logic [CPU_WIDTH-1:0] CAUSE_TMR_IRQ = 32'h8000_0007;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MIE_MTIE     = 7;
    localparam int unsigned MIE_MEIE     = 11;

    typedef enum logic [1:0] {
        EvNone,
        EvExc,
        EvMret,
        EvIrq
    } trap_event_e;

    typedef enum logic [2:0] {
        StIdle,
        StWMepc,
        StWMcause,
        StWMstatus,
        StWMret,
        StAssert
    } trap_state_e;

endpackage

// File: rtl/trap_ctrl_cause_enc.sv
// Qualifies trap and interrupt requests and selects the highest-priority event
// together with its mcause code.
module trap_cause_enc
    import trap_ctrl_pkg::*;
(
    input  logic                 i_ecall,
    input  logic                 i_ebreak,
    input  logic                 i_mret,
    input  logic                 i_ext_irq,
    input  logic                 i_tmr_irq,
    input  logic                 i_mstatus_mie,
    input  logic                 i_mie_meie,
    input  logic                 i_mie_mtie,
    output trap_event_e          o_event,
    output logic [CPU_WIDTH-1:0] o_cause
);

    logic w_ext_en;
    logic w_tmr_en;

    assign w_ext_en = i_ext_irq && i_mstatus_mie && i_mie_meie;
    assign w_tmr_en = i_tmr_irq && i_mstatus_mie && i_mie_mtie;

    always_comb begin
        o_event = EvNone;
        o_cause = '0;
        if (i_ecall) begin
            o_event = EvExc;
            o_cause = CAUSE_ECALL;
        end else if (i_ebreak) begin
            o_event = EvExc;
            o_cause = CAUSE_EBREAK;
        end else if (i_mret) begin
            o_event = EvMret;
        end else if (w_ext_en) begin
            o_event = EvIrq;
            o_cause = CAUSE_EXT_IRQ;
        end else if (w_tmr_en) begin
            o_event = EvIrq;
            o_cause = CAUSE_TMR_IRQ;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: sequences mepc/mcause/mstatus CSR writes and the PC
// redirect for exceptions, interrupts and MRET. Define TRAP_VECTORED_EN for vectored irqs.
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_ecall_i,
    input  logic                 inst_ebreak_i,
    input  logic                 inst_mret_i,
    input  logic [CPU_WIDTH-1:0] inst_addr_i,
    input  logic                 jump_flag_i,
    input  logic [CPU_WIDTH-1:0] jump_addr_i,
    input  logic                 ext_irq_i,
    input  logic                 tmr_irq_i,
    input  logic [CPU_WIDTH-1:0] csr_mtvec_i,
    input  logic [CPU_WIDTH-1:0] csr_mepc_i,
    input  logic [CPU_WIDTH-1:0] csr_mstatus_i,
    input  logic [CPU_WIDTH-1:0] csr_mie_i,
    output logic                 csr_we_o,
    output logic [11:0]          csr_waddr_o,
    output logic [CPU_WIDTH-1:0] csr_wdata_o,
    output logic                 client_hold_flag_o,
    output logic                 client_int_assert_o,
    output logic [CPU_WIDTH-1:0] client_int_addr_o
);

    trap_state_e          r_state;
    trap_state_e          w_state_next;
    trap_event_e          w_event;
    logic [CPU_WIDTH-1:0] w_cause;
    logic                 w_accept;
    logic [CPU_WIDTH-1:0] r_mepc;
    logic [CPU_WIDTH-1:0] r_cause;
    logic                 r_is_mret;
    logic [CPU_WIDTH-1:0] w_mstatus_trap;
    logic [CPU_WIDTH-1:0] w_mstatus_mret;
    logic [CPU_WIDTH-1:0] w_trap_base;
    logic [CPU_WIDTH-1:0] w_trap_target;
    logic [CPU_WIDTH-1:0] w_target;
    logic                 w_unused_bits;

    assign w_unused_bits = ^{csr_mie_i[CPU_WIDTH-1:12], csr_mie_i[10:8], csr_mie_i[6:0],
                             csr_mtvec_i[1:0]};

    trap_cause_enc u_cause_enc (
        .i_ecall       (inst_ecall_i),
        .i_ebreak      (inst_ebreak_i),
        .i_mret        (inst_mret_i),
        .i_ext_irq     (ext_irq_i),
        .i_tmr_irq     (tmr_irq_i),
        .i_mstatus_mie (csr_mstatus_i[MSTATUS_MIE]),
        .i_mie_meie    (csr_mie_i[MIE_MEIE]),
        .i_mie_mtie    (csr_mie_i[MIE_MTIE]),
        .o_event       (w_event),
        .o_cause       (w_cause)
    );

    // Gated by rst so the combinational hold stays low while reset is applied.
    assign w_accept = (r_state == StIdle) && (w_event != EvNone) && !rst;

    always_comb begin
        w_mstatus_trap               = csr_mstatus_i;
        w_mstatus_trap[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
        w_mstatus_trap[MSTATUS_MIE]  = 1'b0;
        w_mstatus_mret               = csr_mstatus_i;
        w_mstatus_mret[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
        w_mstatus_mret[MSTATUS_MPIE] = 1'b1;
    end

    assign w_trap_base = {csr_mtvec_i[CPU_WIDTH-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign w_trap_target = (r_cause[CPU_WIDTH-1] && (csr_mtvec_i[1:0] == 2'b01))
                         ? w_trap_base + CPU_WIDTH'({r_cause[4:0], 2'b00})
                         : w_trap_base;
`else
    assign w_trap_target = w_trap_base;
`endif

    assign w_target = r_is_mret ? csr_mepc_i : w_trap_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_mepc    <= '0;
            r_cause   <= '0;
            r_is_mret <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_mepc    <= (w_event == EvIrq && jump_flag_i) ? jump_addr_i : inst_addr_i;
                r_cause   <= w_cause;
                r_is_mret <= (w_event == EvMret);
            end
        end
    end

    always_comb begin
        w_state_next        = r_state;
        csr_we_o            = 1'b0;
        csr_waddr_o         = '0;
        csr_wdata_o         = '0;
        client_hold_flag_o  = 1'b0;
        client_int_assert_o = 1'b0;
        client_int_addr_o   = '0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    client_hold_flag_o = 1'b1;
                    w_state_next       = (w_event == EvMret) ? StWMret : StWMepc;
                end
            end
            StWMepc: begin
                csr_we_o           = 1'b1;
                csr_waddr_o        = CSR_MEPC;
                csr_wdata_o        = r_mepc;
                client_hold_flag_o = 1'b1;
                w_state_next       = StWMcause;
            end
            StWMcause: begin
                csr_we_o           = 1'b1;
                csr_waddr_o        = CSR_MCAUSE;
                csr_wdata_o        = r_cause;
                client_hold_flag_o = 1'b1;
                w_state_next       = StWMstatus;
            end
            StWMstatus: begin
                csr_we_o           = 1'b1;
                csr_waddr_o        = CSR_MSTATUS;
                csr_wdata_o        = w_mstatus_trap;
                client_hold_flag_o = 1'b1;
                w_state_next       = StAssert;
            end
            StWMret: begin
                csr_we_o           = 1'b1;
                csr_waddr_o        = CSR_MSTATUS;
                csr_wdata_o        = w_mstatus_mret;
                client_hold_flag_o = 1'b1;
                w_state_next       = StAssert;
            end
            StAssert: begin
                client_int_assert_o = 1'b1;
                client_int_addr_o   = w_target;
                w_state_next        = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, hand sequences for
// back-to-back timer and mid-sequence reset, then random events against a reference model.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_ecall_i, inst_ebreak_i, inst_mret_i;
    logic [31:0] inst_addr_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        ext_irq_i, tmr_irq_i;
    logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i, csr_mie_i;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        client_hold_flag_o, client_int_assert_o;
    logic [31:0] client_int_addr_o;

    int n_pass  = 0;
    int n_total = 0;

    trap_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .inst_ecall_i        (inst_ecall_i),
        .inst_ebreak_i       (inst_ebreak_i),
        .inst_mret_i         (inst_mret_i),
        .inst_addr_i         (inst_addr_i),
        .jump_flag_i         (jump_flag_i),
        .jump_addr_i         (jump_addr_i),
        .ext_irq_i           (ext_irq_i),
        .tmr_irq_i           (tmr_irq_i),
        .csr_mtvec_i         (csr_mtvec_i),
        .csr_mepc_i          (csr_mepc_i),
        .csr_mstatus_i       (csr_mstatus_i),
        .csr_mie_i           (csr_mie_i),
        .csr_we_o            (csr_we_o),
        .csr_waddr_o         (csr_waddr_o),
        .csr_wdata_o         (csr_wdata_o),
        .client_hold_flag_o  (client_hold_flag_o),
        .client_int_assert_o (client_int_assert_o),
        .client_int_addr_o   (client_int_addr_o)
    );

    always #5 clk = ~clk;

    // kind: 0 = nothing accepted, 1 = trap (3 writes), 2 = mret (1 write)
    typedef struct {
        logic        ecall, ebreak, mret, ext, tmr, jflag, keep;
        logic [31:0] pc, jaddr, mtvec, mepc, mstatus, mie;
        int          kind;
        logic [31:0] e_mepc, e_cause, e_mstatus, e_target;
    } vec_t;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] VEC_TMR_TGT = 32'h0000_021C;
`else
    localparam logic [31:0] VEC_TMR_TGT = 32'h0000_0200;
`endif

    function automatic vec_t mkv(input logic [4:0] ev, input logic jf,
                                 input logic [31:0] pc, input logic [31:0] ja,
                                 input logic [31:0] mtvec, input logic [31:0] mepc,
                                 input logic [31:0] ms, input logic [31:0] mie, input int kind,
                                 input logic [31:0] em, input logic [31:0] ec,
                                 input logic [31:0] es, input logic [31:0] et);
        vec_t v;
        {v.ecall, v.ebreak, v.mret, v.ext, v.tmr} = ev;
        v.jflag = jf;  v.keep = 1'b0;
        v.pc = pc;  v.jaddr = ja;  v.mtvec = mtvec;  v.mepc = mepc;
        v.mstatus = ms;  v.mie = mie;  v.kind = kind;
        v.e_mepc = em;  v.e_cause = ec;  v.e_mstatus = es;  v.e_target = et;
        return v;
    endfunction

    // Reference model: straight from the architectural trap rules.
    function automatic vec_t model(input vec_t vi);
        vec_t        v;
        logic [31:0] base;
        logic        ext_ok, tmr_ok;
        v = vi;
        v.kind = 0;  v.e_mepc = 0;  v.e_cause = 0;  v.e_mstatus = 0;  v.e_target = 0;
        base   = v.mtvec & 32'hFFFF_FFFC;
        ext_ok = v.ext && v.mstatus[3] && v.mie[11];
        tmr_ok = v.tmr && v.mstatus[3] && v.mie[7];
        if (v.ecall || v.ebreak) begin
            v.kind = 1;  v.e_cause = v.ecall ? 32'd11 : 32'd3;  v.e_mepc = v.pc;
        end else if (v.mret) begin
            v.kind      = 2;
            v.e_mstatus = (v.mstatus & ~32'h88) | 32'h80 | (v.mstatus[7] ? 32'h8 : 32'h0);
            v.e_target  = v.mepc;
        end else if (ext_ok || tmr_ok) begin
            v.kind    = 1;
            v.e_cause = ext_ok ? 32'h8000_000B : 32'h8000_0007;
            v.e_mepc  = v.jflag ? v.jaddr : v.pc;
        end
        if (v.kind == 1) begin
            v.e_mstatus = (v.mstatus & ~32'h88) | (v.mstatus[3] ? 32'h80 : 32'h0);
            v.e_target  = base;
`ifdef TRAP_VECTORED_EN
            if (v.e_cause[31] && (v.mtvec % 4 == 1)) v.e_target = base + 4 * (v.e_cause % 32);
`endif
        end
        return v;
    endfunction

    task automatic check(input string nm, input logic ew, input logic [11:0] ea,
                         input logic [31:0] ed, input logic eh, input logic ei,
                         input logic [31:0] eia);
        n_total++;
        if (csr_we_o === ew && csr_waddr_o === ea && csr_wdata_o === ed &&
            client_hold_flag_o === eh && client_int_assert_o === ei &&
            client_int_addr_o === eia) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got we=%0b waddr=%h wdata=%h hold=%0b int=%0b iaddr=%h; want we=%0b waddr=%h wdata=%h hold=%0b int=%0b iaddr=%h",
                     nm, csr_we_o, csr_waddr_o, csr_wdata_o, client_hold_flag_o,
                     client_int_assert_o, client_int_addr_o, ew, ea, ed, eh, ei, eia);
        end
    endtask

    task automatic apply(input vec_t v);
        inst_ecall_i = v.ecall;  inst_ebreak_i = v.ebreak;  inst_mret_i = v.mret;
        ext_irq_i = v.ext;  tmr_irq_i = v.tmr;  jump_flag_i = v.jflag;
        inst_addr_i = v.pc;  jump_addr_i = v.jaddr;  csr_mtvec_i = v.mtvec;
        csr_mepc_i = v.mepc;  csr_mstatus_i = v.mstatus;  csr_mie_i = v.mie;
    endtask

    task automatic drop_events(input logic keep);
        inst_ecall_i = 1'b0;  inst_ebreak_i = 1'b0;  inst_mret_i = 1'b0;
        if (!keep) begin
            ext_irq_i = 1'b0;  tmr_irq_i = 1'b0;
        end
    endtask

    // Accept cycle, then each CSR write cycle, then the redirect pulse.
    task automatic run_txn(input vec_t v, input string nm);
        logic [11:0] wa[3];
        logic [31:0] wd[3];
        int          nw;
        nw = 0;
        @(negedge clk);
        apply(v);
        #1 check({nm, " accept"}, 1'b0, 12'h0, 32'h0, v.kind != 0, 1'b0, 32'h0);
        if (v.kind == 1) begin
            wa[0] = 12'h341;  wd[0] = v.e_mepc;
            wa[1] = 12'h342;  wd[1] = v.e_cause;
            wa[2] = 12'h300;  wd[2] = v.e_mstatus;
            nw = 3;
        end else if (v.kind == 2) begin
            wa[0] = 12'h300;  wd[0] = v.e_mstatus;
            nw = 1;
        end
        if (v.kind != 0) begin
            for (int i = 0; i < nw; i++) begin
                @(negedge clk);
                drop_events(v.keep);
                #1 check($sformatf("%s write%0d", nm, i), 1'b1, wa[i], wd[i], 1'b1, 1'b0, 32'h0);
            end
            @(negedge clk);
            drop_events(v.keep);
            #1 check({nm, " pulse"}, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, v.e_target);
        end
    endtask

    vec_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vec_t seq_a;
        vec_t seq_b;
        logic [31:0] r;

        tbl[0]  = mkv(5'b10000, 0, 32'h100, 0, 32'h200, 0, 32'h8, 0, 1,
                      32'h100, 32'd11, 32'h80, 32'h200);
        tbl[1]  = mkv(5'b00010, 1, 32'h300, 32'h400, 32'h200, 0, 32'h8, 32'h800, 1,
                      32'h400, 32'h8000_000B, 32'h80, 32'h200);
        tbl[2]  = mkv(5'b00010, 1, 32'h300, 32'h400, 32'h200, 0, 32'h0, 32'h800, 0, 0, 0, 0, 0);
        tbl[3]  = mkv(5'b00100, 0, 32'h500, 0, 32'h200, 32'h104, 32'h80, 0, 2,
                      0, 0, 32'h88, 32'h104);
        tbl[4]  = mkv(5'b10001, 0, 32'h120, 0, 32'h200, 0, 32'h8, 32'h80, 1,
                      32'h120, 32'd11, 32'h80, 32'h200);
        tbl[5]  = mkv(5'b01000, 1, 32'h44, 32'h998, 32'h200, 0, 32'h1808, 0, 1,
                      32'h44, 32'd3, 32'h1880, 32'h200);
        tbl[6]  = mkv(5'b00001, 0, 32'h60, 0, 32'h200, 0, 32'h8, 32'h800, 0, 0, 0, 0, 0);
        tbl[7]  = mkv(5'b00001, 0, 32'h50, 32'h70, 32'h203, 0, 32'h8, 32'h80, 1,
                      32'h50, 32'h8000_0007, 32'h80, 32'h200);
        tbl[8]  = mkv(5'b00011, 0, 32'h64, 0, 32'h300, 0, 32'h88, 32'h880, 1,
                      32'h64, 32'h8000_000B, 32'h80, 32'h300);
        tbl[9]  = mkv(5'b00110, 0, 32'h70, 0, 32'h200, 32'h2A0, 32'h8, 32'h800, 2,
                      0, 0, 32'h80, 32'h2A0);
        tbl[10] = mkv(5'b00001, 0, 32'h80, 0, 32'h201, 0, 32'h8, 32'h80, 1,
                      32'h80, 32'h8000_0007, 32'h80, VEC_TMR_TGT);
        tbl[11] = mkv(5'b10000, 0, 32'h84, 0, 32'h201, 0, 32'h8, 32'h80, 1,
                      32'h84, 32'd11, 32'h80, 32'h200);
        tbl[12] = mkv(5'b01000, 0, 32'h88, 0, 32'h200, 0, 32'h0, 0, 1,
                      32'h88, 32'd3, 32'h0, 32'h200);
        tbl[13] = mkv(5'b00011, 0, 32'h8C, 0, 32'h200, 0, 32'h8, 32'h777, 0, 0, 0, 0, 0);
        tbl[14] = mkv(5'b00100, 0, 32'h90, 0, 32'h200, 32'h10, 32'hFFFF_FF77, 0, 2,
                      0, 0, 32'hFFFF_FFF7, 32'h10);

        // Reset with an ecall pending: outputs must stay quiet.
        rst = 1'b1;
        apply(tbl[0]);
        repeat (2) @(negedge clk);
        #1 check("reset", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drop_events(1'b0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Timer stays high through an ecall and must be taken right after return to idle.
        seq_a = mkv(5'b10001, 0, 32'h120, 0, 32'h200, 0, 32'h8, 32'h80, 1,
                    32'h120, 32'd11, 32'h80, 32'h200);
        seq_a.keep = 1'b1;
        run_txn(seq_a, "tmr_hold_ecall");
        seq_b = mkv(5'b00001, 0, 32'h124, 0, 32'h200, 0, 32'h8, 32'h80, 1,
                    32'h124, 32'h8000_0007, 32'h80, 32'h200);
        run_txn(seq_b, "tmr_hold_take");

        // Reset in the middle of a trap sequence.
        @(negedge clk);
        apply(tbl[0]);
        #1 check("rst_seq accept", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drop_events(1'b0);
        #1 check("rst_seq mepc", 1'b1, 12'h341, 32'h100, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        #1 check("rst_seq mcause", 1'b1, 12'h342, 32'd11, 1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        #1 check("rst_seq in_reset", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 check($sformatf("rst_seq quiet%0d", i), 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        end

        for (int n = 0; n < 300; n++) begin
            v.ecall  = ($urandom_range(0, 7) == 0);
            v.ebreak = ($urandom_range(0, 7) == 0);
            v.mret   = ($urandom_range(0, 5) == 0);
            v.ext    = ($urandom_range(0, 2) == 0);
            v.tmr    = ($urandom_range(0, 2) == 0);
            v.jflag  = ($urandom_range(0, 1) == 1);
            v.keep   = ($urandom_range(0, 1) == 1);
            v.pc     = $urandom & 32'hFFFF_FFFC;
            v.jaddr  = $urandom & 32'hFFFF_FFFC;
            r        = $urandom;
            v.mtvec  = (r & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
            v.mepc   = $urandom;
            v.mstatus = $urandom;
            v.mie    = $urandom;
            v = model(v);
            run_txn(v, $sformatf("rnd%0d", n));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
